// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a byte FIFO in front of it.
// Bytes are sent LSB first, DELAY_FRAMES clock cycles per bit, back to back when queued.
module uart_tx_fifo #(
    parameter int unsigned DELAY_FRAMES = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dataIn,
    input  logic       dataValid,
    output logic       fifoFull,
    output logic       fifoEmpty,
    output logic       overflow,
    output logic       txBusy,
    output logic       byteSent,
    output logic       uartTx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = $clog2(DELAY_FRAMES);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [DW-1:0] LAST_CYC = DW'(DELAY_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d, busy_d, sent_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic          push, pop;

    assign fifoFull  = (count_q == DEPTH_C);
    assign fifoEmpty = (count_q == '0);
    assign overflow  = overflow_q;
    // Fullness is judged before the edge, so a pop on the same edge never frees a slot early.
    assign push      = dataValid && !fifoFull;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_q | (dataValid & fifoFull);
        end
    end

    // State register, counters and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            uartTx   <= 1'b1;
            txBusy   <= 1'b0;
            byteSent <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            uartTx   <= tx_d;
            txBusy   <= busy_d;
            byteSent <= sent_d;
        end
    end

    // Next-state logic; STOP pops directly into START so queued frames have no gap.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = START;
                    cyc_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + DW'(1);
                end
            end
            DATA: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + DW'(1);
                end
            end
            STOP: begin
                if (cyc_q == LAST_CYC) begin
                    cyc_d = '0;
                    bit_d = '0;
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, captured by the output registers.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        sent_d = (state_d == STOP) && (cyc_d == LAST_CYC);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-level reference model built from frame position arithmetic
// and a byte queue, plus directed checks on the documented scenarios.
module tb_uart_tx_fifo;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FRAME = 10 * D;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dataValid = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       fifoFull, fifoEmpty, overflow, txBusy, byteSent, uartTx;
    logic [5:0] obs;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_busy;
    int         m_t;
    logic [7:0] m_byte;
    bit         m_ovf;

    uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
        .fifoFull(fifoFull), .fifoEmpty(fifoEmpty), .overflow(overflow),
        .txBusy(txBusy), .byteSent(byteSent), .uartTx(uartTx)
    );

    always #5 clk = ~clk;

    assign obs = {uartTx, txBusy, byteSent, fifoFull, fifoEmpty, overflow};

    function automatic logic [5:0] exp_vec();
        int   bp;
        logic tx;
        bp = m_t / int'(D);
        if (!m_busy)      tx = 1'b1;
        else if (bp == 0) tx = 1'b0;
        else if (bp <= 8) tx = m_byte[bp-1];
        else              tx = 1'b1;
        return {tx, m_busy, (m_busy && m_t == int'(FRAME) - 1),
                (m_q.size() == int'(DEPTH)), (m_q.size() == 0), m_ovf};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = 0;
        m_t    = 0;
        m_ovf  = 0;
        m_byte = 8'h00;
    endtask

    // One clock: drive inputs, advance DUT and model together, settle past the edge.
    task automatic tick(input logic v, input logic [7:0] d);
        bit full;
        dataValid = v;
        dataIn    = d;
        @(posedge clk);
        full = (m_q.size() == int'(DEPTH));
        if (!m_busy || m_t == int'(FRAME) - 1) begin
            if (m_q.size() > 0) begin
                m_byte = m_q.pop_front();
                m_busy = 1;
                m_t    = 0;
            end else begin
                m_busy = 0;
            end
        end else begin
            m_t++;
        end
        if (v && !full) m_q.push_back(d);
        if (v && full)  m_ovf = 1;
        #1;
        dataValid = 1'b0;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        dataValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (uartTx !== 1'b1)    begin errors++; $display("FAIL reset_uartTx got %b want 1", uartTx); end
        vectors++; if (fifoEmpty !== 1'b1) begin errors++; $display("FAIL reset_fifoEmpty got %b want 1", fifoEmpty); end
        vectors++; if (fifoFull !== 1'b0)  begin errors++; $display("FAIL reset_fifoFull got %b want 0", fifoFull); end
        vectors++; if (txBusy !== 1'b0)    begin errors++; $display("FAIL reset_txBusy got %b want 0", txBusy); end
        vectors++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        vectors++; if (byteSent !== 1'b0)  begin errors++; $display("FAIL reset_byteSent got %b want 0", byteSent); end
    endtask

    task automatic test_single_byte();
        logic [7:0] pat;
        logic       line [50];
        logic       busy [50];
        int         sent_at;
        pat     = 8'hA5;
        sent_at = -1;
        tick(1'b1, pat);
        line[0] = uartTx;
        busy[0] = txBusy;
        vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL single cyc 0 got %b want %b", obs, exp_vec()); end
        for (int k = 1; k < 50; k++) begin
            tick(1'b0, 8'h00);
            line[k] = uartTx;
            busy[k] = txBusy;
            if (byteSent === 1'b1 && sent_at < 0) sent_at = k;
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL single cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        vectors++; if (line[0] !== 1'b1) begin errors++; $display("FAIL single_latency tx got %b want 1", line[0]); end
        for (int k = 1; k <= int'(D); k++) begin
            vectors++; if (line[k] !== 1'b0) begin errors++; $display("FAIL single_start cyc %0d got %b want 0", k, line[k]); end
        end
        for (int b = 0; b < 8; b++) begin
            vectors++;
            if (line[(b+1)*int'(D) + 1 + int'(D)/2] !== pat[b]) begin
                errors++; $display("FAIL single_bit%0d got %b want %b", b, line[(b+1)*int'(D) + 1 + int'(D)/2], pat[b]);
            end
        end
        vectors++; if (line[9*int'(D) + 2] !== 1'b1) begin errors++; $display("FAIL single_stop got %b want 1", line[9*int'(D) + 2]); end
        vectors++; if (sent_at != 40) begin errors++; $display("FAIL single_sent_cycle got %0d want 40", sent_at); end
        vectors++; if (busy[40] !== 1'b1 || busy[41] !== 1'b0) begin
            errors++; $display("FAIL single_busy_drop got %b%b want 10", busy[40], busy[41]);
        end
    endtask

    task automatic test_back_to_back();
        int sent[$];
        int gaps;
        logic [7:0] bytes [3];
        bytes[0] = 8'h55; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
        gaps = 0;
        for (int k = 0; k < 131; k++) begin
            tick(k < 3, (k < 3) ? bytes[k] : 8'h00);
            if (byteSent === 1'b1) sent.push_back(k);
            if (k >= 1 && k <= 120 && txBusy !== 1'b1) gaps++;
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL b2b cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        vectors++; if (sent.size() != 3) begin errors++; $display("FAIL b2b_pulses got %0d want 3", sent.size()); end
        else begin
            vectors++; if (sent[0] != 40 || sent[1] != 80 || sent[2] != 120) begin
                errors++; $display("FAIL b2b_spacing got %0d %0d %0d want 40 80 120", sent[0], sent[1], sent[2]);
            end
        end
        vectors++; if (gaps != 0) begin errors++; $display("FAIL b2b_idle_gap got %0d idle cycles want 0", gaps); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            tick($urandom_range(0, 19) == 0, 8'($urandom));
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        for (int k = 0; k < 6 * int'(FRAME); k++) begin
            tick(1'b0, 8'h00);
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL random_drain cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
    endtask

    task automatic test_overflow();
        int pulses;
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'h30 + i));
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL ovf wr %0d got %b want %b", i, obs, exp_vec()); end
        end
        vectors++; if (fifoFull !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_flags full=%b ovf=%b want 1 1", fifoFull, overflow);
        end
        for (int k = 0; k < 5 * int'(FRAME) + 10; k++) begin
            tick(1'b0, 8'h00);
            if (byteSent === 1'b1) pulses++;
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL ovf_drain cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        vectors++; if (pulses != 5) begin errors++; $display("FAIL ovf_frames got %0d want 5", pulses); end
    endtask

    task automatic test_full_boundary();
        bit found;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 8'(8'hC0 + i));
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL bnd fill %0d got %b want %b", i, obs, exp_vec()); end
        end
        vectors++; if (fifoFull !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL bnd_prefill full=%b ovf=%b want 1 0", fifoFull, overflow);
        end
        found = 0;
        for (int k = 0; k < int'(FRAME) + 2 && !found; k++) begin
            tick(1'b0, 8'h00);
            if (byteSent === 1'b1) found = 1;
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL bnd_wait cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        vectors++; if (!found) begin errors++; $display("FAIL bnd_timeout byteSent got 0 want 1"); end
        tick(1'b1, 8'hEE);
        vectors++; if (overflow !== 1'b1 || fifoFull !== 1'b0 || fifoEmpty !== 1'b0) begin
            errors++; $display("FAIL bnd_pop_write ovf=%b full=%b empty=%b want 1 0 0", overflow, fifoFull, fifoEmpty);
        end
        for (int k = 0; k < 4 * int'(FRAME) + 10; k++) begin
            tick(1'b0, 8'h00);
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL bnd_drain cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
    endtask

    task automatic test_midframe_reset();
        int lows;
        apply_reset();
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        for (int k = 0; k < 3 * int'(FRAME) && m_t != 4 * int'(D) + 1; k++) begin
            tick(1'b0, 8'h00);
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL mid_run cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        vectors++; if (txBusy !== 1'b1 || uartTx !== 1'b0 || fifoEmpty !== 1'b0) begin
            errors++; $display("FAIL mid_pre busy=%b tx=%b empty=%b want 1 0 0", txBusy, uartTx, fifoEmpty);
        end
        reset = 1'b1;
        #2;
        vectors++; if (uartTx !== 1'b1 || fifoEmpty !== 1'b1 || txBusy !== 1'b0) begin
            errors++; $display("FAIL mid_abort tx=%b empty=%b busy=%b want 1 1 0", uartTx, fifoEmpty, txBusy);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        lows = 0;
        for (int k = 0; k < 60; k++) begin
            tick(1'b0, 8'h00);
            if (uartTx !== 1'b1) lows++;
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL mid_idle cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
        vectors++; if (lows != 0) begin errors++; $display("FAIL mid_quiet got %0d low cycles want 0", lows); end
        tick(1'b1, 8'h5A);
        for (int k = 0; k < int'(FRAME) + 4; k++) begin
            tick(1'b0, 8'h00);
            vectors++; if (obs !== exp_vec()) begin errors++; $display("FAIL mid_resume cyc %0d got %b want %b", k, obs, exp_vec()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_random();
        test_overflow();
        test_full_boundary();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
